// File: rtl/hilo_div_unit.sv
// HI/LO special registers plus an iterative restoring radix-2 divider for DIV/DIVU.
// A divide takes a fixed WIDTH+2 cycles and holds the pipeline stalled while it runs.
module hilo_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [1:0]       hilowrite,
  input  logic [WIDTH-1:0] hi_wdata,
  input  logic [WIDTH-1:0] lo_wdata,
  input  logic             flush,
  output logic             div_stall,
  output logic             div_done,
  output logic [WIDTH-1:0] hi_rdata,
  output logic [WIDTH-1:0] lo_rdata
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] negate_f(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // The most negative value maps onto itself, which is the right unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude_f(input logic [WIDTH-1:0] v,
                                                   input logic             sgn);
    return (sgn && v[WIDTH-1]) ? negate_f(v) : v;
  endfunction

  state_t           state_r;
  state_t           state_nx_s;
  logic [CNT_W-1:0] count_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvsr_r;
  logic [WIDTH-1:0] raw_a_r;
  logic             q_neg_r;
  logic             r_neg_r;
  logic             dz_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  logic             accept_s;
  logic             last_s;
  logic [WIDTH:0]   shifted_s;
  logic             ge_s;
  logic [WIDTH-1:0] rem_nx_s;
  logic [WIDTH-1:0] quo_nx_s;
  logic [WIDTH-1:0] q_fin_s;
  logic [WIDTH-1:0] r_fin_s;

  assign accept_s = (state_r == ST_IDLE) && div_start && !flush;
  assign last_s   = (count_r == LAST_STEP);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; flush returns to IDLE from anywhere.
  always_comb begin
    state_nx_s = state_r;
    if (flush) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_nx_s = ST_DIV;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_DIV: begin
          if (last_s) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_DIV;
          end
        end
        ST_DONE: state_nx_s = ST_IDLE;
        default: state_nx_s = ST_IDLE;
      endcase
    end
  end

  // Stall and done decode; a flush drops both in the same cycle.
  always_comb begin
    div_stall = 1'b0;
    div_done  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        div_stall = div_start && !flush;
        div_done  = 1'b0;
      end
      ST_DIV: begin
        div_stall = !flush;
        div_done  = 1'b0;
      end
      ST_DONE: begin
        div_stall = 1'b0;
        div_done  = !flush;
      end
      default: begin
        div_stall = 1'b0;
        div_done  = 1'b0;
      end
    endcase
  end

  // One restoring step: shift in the next dividend bit, subtract when it fits.
  always_comb begin
    shifted_s = {rem_r, quo_r[WIDTH-1]};
    ge_s      = (shifted_s >= {1'b0, dvsr_r});
    if (ge_s) begin
      rem_nx_s = shifted_s[WIDTH-1:0] - dvsr_r;
      quo_nx_s = {quo_r[WIDTH-2:0], 1'b1};
    end else begin
      rem_nx_s = shifted_s[WIDTH-1:0];
      quo_nx_s = {quo_r[WIDTH-2:0], 1'b0};
    end
  end

  // Sign fix-up, with divide-by-zero results forced.
  always_comb begin
    if (dz_r) begin
      q_fin_s = {WIDTH{1'b1}};
      r_fin_s = raw_a_r;
    end else begin
      q_fin_s = q_neg_r ? negate_f(quo_r) : quo_r;
      r_fin_s = r_neg_r ? negate_f(rem_r) : rem_r;
    end
  end

  // Divider datapath: operand capture on accept, one step per DIV cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
      rem_r   <= {WIDTH{1'b0}};
      quo_r   <= {WIDTH{1'b0}};
      dvsr_r  <= {WIDTH{1'b0}};
      raw_a_r <= {WIDTH{1'b0}};
      q_neg_r <= 1'b0;
      r_neg_r <= 1'b0;
      dz_r    <= 1'b0;
    end else if (flush) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (div_start) begin
            count_r <= {CNT_W{1'b0}};
            rem_r   <= {WIDTH{1'b0}};
            quo_r   <= magnitude_f(src_a, div_signed);
            dvsr_r  <= magnitude_f(src_b, div_signed);
            raw_a_r <= src_a;
            q_neg_r <= div_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            r_neg_r <= div_signed & src_a[WIDTH-1];
            dz_r    <= (src_b == {WIDTH{1'b0}});
          end
        end
        ST_DIV: begin
          rem_r   <= rem_nx_s;
          quo_r   <= quo_nx_s;
          count_r <= count_r + CNT_ONE;
        end
        ST_DONE: count_r <= {CNT_W{1'b0}};
        default: count_r <= {CNT_W{1'b0}};
      endcase
    end
  end

  // HI/LO: the divide result takes priority over a decoder write in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r <= {WIDTH{1'b0}};
      lo_r <= {WIDTH{1'b0}};
    end else if (flush) begin
      hi_r <= hi_r;
      lo_r <= lo_r;
    end else if (state_r == ST_DONE) begin
      hi_r <= r_fin_s;
      lo_r <= q_fin_s;
    end else begin
      if (hilowrite[1]) begin
        hi_r <= hi_wdata;
      end
      if (hilowrite[0]) begin
        lo_r <= lo_wdata;
      end
    end
  end

  assign hi_rdata = hi_r;
  assign lo_rdata = lo_r;

endmodule

// File: tb/tb_hilo_div_unit.sv
// Self-checking bench for hilo_div_unit: directed and random divides against an
// arithmetic reference, HI/LO writes, flush, mid-divide reset and back-to-back issue.
module tb_hilo_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         div_start = 1'b0;
  logic         div_signed = 1'b0;
  logic [W-1:0] src_a = 32'h0;
  logic [W-1:0] src_b = 32'h0;
  logic [1:0]   hilowrite = 2'b00;
  logic [W-1:0] hi_wdata = 32'h0;
  logic [W-1:0] lo_wdata = 32'h0;
  logic         flush = 1'b0;
  logic         div_stall;
  logic         div_done;
  logic [W-1:0] hi_rdata;
  logic [W-1:0] lo_rdata;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [W-1:0] hi_m = 32'h0;
  logic [W-1:0] lo_m = 32'h0;

  hilo_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .div_start(div_start), .div_signed(div_signed),
    .src_a(src_a), .src_b(src_b), .hilowrite(hilowrite), .hi_wdata(hi_wdata),
    .lo_wdata(lo_wdata), .flush(flush), .div_stall(div_stall), .div_done(div_done),
    .hi_rdata(hi_rdata), .lo_rdata(lo_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: MIPS DIV/DIVU semantics from plain integer arithmetic.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sgn, output logic [W-1:0] q,
                                  output logic [W-1:0] r);
    longint sa, sb, sq, sr;
    if (b == 32'h0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sq = sa / sb;
      sr = sa % sb;
      q = sq[31:0];
      r = sr[31:0];
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic write_hilo(input logic [1:0] sel, input logic [W-1:0] h, input logic [W-1:0] l);
    hilowrite = sel; hi_wdata = h; lo_wdata = l;
    @(posedge clk); #1;
    hilowrite = 2'b00;
    if (sel[1]) hi_m = h;
    if (sel[0]) lo_m = l;
  endtask

  task automatic test_reset();
    rst = 1'b1; div_start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (hi_rdata !== 32'h0 || lo_rdata !== 32'h0 || div_stall !== 1'b0 || div_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_state hi=%h lo=%h stall=%b done=%b required 0/0/0/0",
               hi_rdata, lo_rdata, div_stall, div_done);
    end
    div_start = 1'b1; #1;
    checks++;
    if (div_stall !== 1'b1) begin
      failures++;
      $display("FAIL reset_stall_follows_start stall=%b required 1", div_stall);
    end
    div_start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    hi_m = 32'h0; lo_m = 32'h0;
  endtask

  task automatic test_hilowrite();
    logic [W-1:0] h, l;
    for (int k = 0; k < 4; k++) begin
      h = (k == 0) ? 32'h0000_1234 : $urandom;
      l = $urandom;
      case (k)
        0: write_hilo(2'b10, h, l);
        1: write_hilo(2'b01, h, l);
        2: write_hilo(2'b11, h, l);
        default: write_hilo(2'b00, h, l);
      endcase
      @(negedge clk);
      checks++;
      if (hi_rdata !== hi_m || lo_rdata !== lo_m) begin
        failures++;
        $display("FAIL hilowrite k=%0d hi=%h lo=%h required hi=%h lo=%h",
                 k, hi_rdata, lo_rdata, hi_m, lo_m);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                        input bit collide, output int done_cyc);
    logic [W-1:0] eq, er;
    bit bad;
    ref_div(a, b, sgn, eq, er);
    div_start = 1'b1; div_signed = sgn; src_a = a; src_b = b;
    @(negedge clk);
    checks++;
    if (div_stall !== 1'b1) begin
      failures++;
      $display("FAIL div_accept_stall stall=%b required 1", div_stall);
    end
    bad = 1'b0;
    for (int i = 1; i <= W; i++) begin
      @(posedge clk); #1;
      src_a = $urandom; src_b = $urandom; div_signed = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (div_stall !== 1'b1 || div_done !== 1'b0 || hi_rdata !== hi_m || lo_rdata !== lo_m) begin
        if (!bad)
          $display("FAIL div_busy T+%0d stall=%b done=%b hi=%h lo=%h required 1/0/%h/%h",
                   i, div_stall, div_done, hi_rdata, lo_rdata, hi_m, lo_m);
        bad = 1'b1;
      end
    end
    checks++;
    if (bad) failures++;
    @(posedge clk); #1;
    if (collide) begin
      hilowrite = 2'b11; hi_wdata = ~er; lo_wdata = ~eq;
    end
    @(negedge clk);
    done_cyc = cyc;
    checks++;
    if (div_stall !== 1'b0 || div_done !== 1'b1) begin
      failures++;
      $display("FAIL div_done_cycle stall=%b done=%b required 0/1", div_stall, div_done);
    end
    @(posedge clk); #1;
    div_start = 1'b0; hilowrite = 2'b00;
    hi_m = er; lo_m = eq;
    checks++;
    if (lo_rdata !== eq || hi_rdata !== er) begin
      failures++;
      $display("FAIL div_result a=%h b=%h s=%0d lo=%h hi=%h required lo=%h hi=%h",
               a, b, sgn, lo_rdata, hi_rdata, eq, er);
    end
  endtask

  task automatic test_directed_div();
    int d;
    do_div(32'd7, 32'd2, 1'b0, 1'b0, d);
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, d);
    do_div(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, d);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, d);
    do_div(32'd5, 32'd0, 1'b0, 1'b0, d);
    do_div(32'hFFFF_FFF0, 32'd0, 1'b1, 1'b0, d);
    do_div(32'd100, 32'd7, 1'b0, 1'b1, d);
  endtask

  task automatic test_random_div();
    logic [W-1:0] a, b;
    int d;
    for (int k = 0; k < 10; k++) begin
      a = (k % 5 == 4) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = $urandom_range(1, 16);
        2: b = 32'hFFFF_FFFF;
        default: b = (k % 3 == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 30));
      endcase
      do_div(a, b, 1'($urandom_range(0, 1)), 1'b0, d);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_flush();
    int stray;
    write_hilo(2'b11, 32'hCAFE_0001, 32'hBEEF_0002);
    div_start = 1'b1; div_signed = 1'b0; src_a = 32'd1000; src_b = 32'd3;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1; hilowrite = 2'b11; hi_wdata = 32'h1111_1111; lo_wdata = 32'h2222_2222;
    @(negedge clk);
    checks++;
    if (div_stall !== 1'b0 || div_done !== 1'b0) begin
      failures++;
      $display("FAIL flush_stall_drop stall=%b done=%b required 0/0", div_stall, div_done);
    end
    @(posedge clk); #1;
    flush = 1'b0; div_start = 1'b0; hilowrite = 2'b00;
    @(negedge clk);
    checks++;
    if (div_stall !== 1'b0 || hi_rdata !== hi_m || lo_rdata !== lo_m) begin
      failures++;
      $display("FAIL flush_idle stall=%b hi=%h lo=%h required 0/%h/%h",
               div_stall, hi_rdata, lo_rdata, hi_m, lo_m);
    end
    stray = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (div_done !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0 || hi_rdata !== hi_m || lo_rdata !== lo_m) begin
      failures++;
      $display("FAIL flush_no_done stray_done=%0d hi=%h lo=%h required 0/%h/%h",
               stray, hi_rdata, lo_rdata, hi_m, lo_m);
    end
  endtask

  task automatic test_reset_mid();
    int stray;
    write_hilo(2'b11, 32'h0BAD_F00D, 32'h1357_9BDF);
    div_start = 1'b1; div_signed = 1'b1; src_a = 32'hFFFF_0000; src_b = 32'd9;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1; div_start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (hi_rdata !== 32'h0 || lo_rdata !== 32'h0 || div_stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid hi=%h lo=%h stall=%b required 0/0/0", hi_rdata, lo_rdata, div_stall);
    end
    hi_m = 32'h0; lo_m = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    stray = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (div_done !== 1'b0 || div_stall !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL reset_mid_quiet stray_cycles=%0d required 0", stray);
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    do_div(32'd9, 32'd3, 1'b0, 1'b0, d1);
    do_div(32'd10, 32'd4, 1'b0, 1'b0, d2);
    checks++;
    if (d2 - d1 != 34) begin
      failures++;
      $display("FAIL back_to_back_spacing got=%0d required 34", d2 - d1);
    end
  endtask

  initial begin
    test_reset();
    test_hilowrite();
    test_directed_div();
    test_random_div();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
